// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for mem_bus_arbiter: fetch/data request ports, RAM port and status.
// The arbiter uses the slave view; the surrounding system (requesters + RAM) uses master.
interface mem_bus_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic [DATA_W-1:0] if_rdata;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_ack;
   logic [DATA_W-1:0] dm_rdata;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              busy;
   logic              owner;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata,
      output if_ack, if_rdata, dm_ack, dm_rdata, ram_en, ram_we, ram_addr, ram_wdata,
             busy, owner
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata,
      input  if_ack, if_rdata, dm_ack, dm_rdata, ram_en, ram_we, ram_addr, ram_wdata,
             busy, owner
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Single owner of the shared I/D RAM port; arbitrates fetch vs LDR/STR with a small FSM.
// Define ARB_RR_EN for round-robin on ties; default is fixed priority (data wins).
module mem_bus_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input logic            clock,
   input logic            reset,
   mem_bus_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   state_t     state, state_nxt;
   logic [2:0] lat_cnt;
   logic       lat_we;
   logic       grant_dm, grant_if;
`ifdef ARB_RR_EN
   logic       last_owner;
`endif

   always_comb begin
      grant_dm  = 1'b0;
      grant_if  = 1'b0;
      state_nxt = state;
      case (state)
         IDLE: begin
`ifdef ARB_RR_EN
            // On a tie, grant the port that did not win last time.
            if (bus.dm_req && bus.if_req) begin
               grant_dm = !last_owner;
               grant_if = last_owner;
            end else begin
               grant_dm = bus.dm_req;
               grant_if = bus.if_req;
            end
`else
            grant_dm = bus.dm_req;
            grant_if = bus.if_req && !bus.dm_req;
`endif
            if (grant_dm || grant_if) state_nxt = ACCESS;
         end
         ACCESS:  state_nxt = lat_we ? RESP : WAIT;
         WAIT:    if (lat_cnt == 3'd1) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         lat_cnt       <= 3'd0;
         lat_we        <= 1'b0;
         bus.busy      <= 1'b0;
         bus.owner     <= 1'b0;
         bus.ram_en    <= 1'b0;
         bus.ram_we    <= 1'b0;
         bus.ram_addr  <= '0;
         bus.ram_wdata <= '0;
         bus.if_ack    <= 1'b0;
         bus.dm_ack    <= 1'b0;
         bus.if_rdata  <= '0;
         bus.dm_rdata  <= '0;
`ifdef ARB_RR_EN
         last_owner    <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         // Outputs are decoded from the next state so every one leaves a flop.
         bus.busy   <= (state_nxt != IDLE);
         bus.ram_en <= (state_nxt == ACCESS);
         bus.ram_we <= 1'b0;
         bus.if_ack <= 1'b0;
         bus.dm_ack <= 1'b0;

         // ram_addr/ram_wdata double as the request latches and hold between accesses.
         if (grant_dm) begin
            bus.owner     <= 1'b1;
            lat_we        <= bus.dm_we;
            bus.ram_we    <= bus.dm_we;
            bus.ram_addr  <= bus.dm_addr;
            bus.ram_wdata <= bus.dm_wdata;
         end else if (grant_if) begin
            bus.owner    <= 1'b0;
            lat_we       <= 1'b0;
            bus.ram_addr <= bus.if_addr;
         end
`ifdef ARB_RR_EN
         if (grant_dm || grant_if) last_owner <= grant_dm;
`endif

         if (state == ACCESS)   lat_cnt <= 3'(RD_LAT);
         else if (state == WAIT) lat_cnt <= lat_cnt - 3'd1;

         if (state == WAIT && lat_cnt == 3'd1) begin
            if (bus.owner) bus.dm_rdata <= bus.ram_rdata;
            else           bus.if_rdata <= bus.ram_rdata;
         end

         if (state_nxt == RESP) begin
            if (bus.owner) bus.dm_ack <= 1'b1;
            else           bus.if_ack <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table plus cycle-exact corner sequences,
// with a scoreboard queue matching every ack against the expected port and data.
module tb_mem_bus_arbiter;
   localparam int AW = 16;
   localparam int DW = 32;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
   mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();

   mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut1 (
      .clock(clock), .reset(reset), .bus(b1)
   );
   mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
      .clock(clock), .reset(reset), .bus(b3)
   );

   // RAM for dut1: 1-cycle read; rdata is junk outside the valid cycle.
   logic [DW-1:0] mem1 [0:255];
   logic          rv1 = 1'b0;
   logic [DW-1:0] rd1 = '0;
   always @(posedge clock) begin
      rv1 <= b1.ram_en && !b1.ram_we;
      rd1 <= mem1[b1.ram_addr[7:0]];
      if (b1.ram_en && b1.ram_we) mem1[b1.ram_addr[7:0]] <= b1.ram_wdata;
   end
   assign b1.ram_rdata = rv1 ? rd1 : 32'hBAD0_BAD0;

   function automatic logic [DW-1:0] pat(logic [AW-1:0] a);
      return {a ^ 16'h5A5A, ~a};
   endfunction

   // RAM for dut3: 3-cycle read of a fixed pattern.
   logic [2:0]    rv3 = 3'b0;
   logic [DW-1:0] rd3 [0:2];
   always @(posedge clock) begin
      rv3    <= {rv3[1:0], b3.ram_en && !b3.ram_we};
      rd3[0] <= pat(b3.ram_addr);
      rd3[1] <= rd3[0];
      rd3[2] <= rd3[1];
   end
   assign b3.ram_rdata = rv3[2] ? rd3[2] : 32'hBAD0_BAD0;

   int errors = 0;
   int checks = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic        dat;
      logic        rd;
      logic [31:0] data;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   logic [DW-1:0] shadow [0:255];

   always @(negedge clock) begin
      if (b1.if_ack || b1.dm_ack) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: if_ack=%b dm_ack=%b with no pending access",
                     b1.if_ack, b1.dm_ack);
         end else begin
            mon_e = sb.pop_front();
            chk("ack_exclusive", {31'b0, b1.if_ack & b1.dm_ack}, 32'd0);
            chk("ack_port", {31'b0, b1.dm_ack}, {31'b0, mon_e.dat});
            if (mon_e.rd)
               chk(mon_e.dat ? "dm_rdata" : "if_rdata",
                   mon_e.dat ? b1.dm_rdata : b1.if_rdata, mon_e.data);
         end
      end
   end

   task automatic nxt(); @(posedge clock); #1; endtask
   task automatic smp(); @(negedge clock); endtask

   task automatic expect_push(bit dat, bit we, logic [15:0] a, logic [31:0] wd);
      exp_t e;
      if (dat && we) shadow[a[7:0]] = wd;
      e.dat  = dat;
      e.rd   = !(dat && we);
      e.data = shadow[a[7:0]];
      sb.push_back(e);
   endtask

   task automatic drive(bit dat, bit we, logic [15:0] a, logic [31:0] wd);
      if (dat) begin
         b1.dm_req = 1'b1; b1.dm_we = we; b1.dm_addr = a; b1.dm_wdata = wd;
      end else begin
         b1.if_req = 1'b1; b1.if_addr = a;
      end
   endtask

   // Returns the cycle (relative to cycle 0 = request seen in IDLE) of the ack, -1 on timeout.
   task automatic wait_ack(bit dat, output int lat);
      lat = -1;
      for (int t = 0; t < 20; t++) begin
         smp();
         if (dat ? b1.dm_ack : b1.if_ack) begin
            lat = t;
            break;
         end
         nxt();
      end
      nxt();
      if (dat) b1.dm_req = 1'b0; else b1.if_req = 1'b0;
   endtask

   typedef struct {
      bit          dat;
      bit          we;
      logic [15:0] addr;
      logic [31:0] wdata;
      int          lat;
   } vec_t;

   vec_t tv [12];
   bit   ord [4];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int n;
      tv[0]  = '{1, 1, 16'h0010, 32'hDEADBEEF, 2};
      tv[1]  = '{1, 1, 16'h0020, 32'h12345678, 2};
      tv[2]  = '{0, 0, 16'h0020, 32'h0,        3};
      tv[3]  = '{1, 1, 16'h0030, 32'hA5A5A5A5, 2};
      tv[4]  = '{1, 0, 16'h0030, 32'h0,        3};
      tv[5]  = '{1, 1, 16'h0000, 32'h13579BDF, 2};
      tv[6]  = '{0, 0, 16'h0000, 32'h0,        3};
      tv[7]  = '{1, 1, 16'h00FF, 32'hFFFFFFFF, 2};
      tv[8]  = '{1, 0, 16'h00FF, 32'h0,        3};
      tv[9]  = '{0, 0, 16'h0010, 32'h0,        3};
      tv[10] = '{1, 1, 16'h0040, 32'h0F0F0F0F, 2};
      tv[11] = '{0, 0, 16'h0040, 32'h0,        3};
`ifdef ARB_RR_EN
      ord = '{1, 0, 1, 0};
`else
      ord = '{1, 1, 1, 1};
`endif

      b1.if_req = 0; b1.if_addr = '0; b1.dm_req = 0; b1.dm_we = 0; b1.dm_addr = '0; b1.dm_wdata = '0;
      b3.if_req = 0; b3.if_addr = '0; b3.dm_req = 0; b3.dm_we = 0; b3.dm_addr = '0; b3.dm_wdata = '0;
      reset = 1'b1;
      repeat (3) nxt();
      smp();
      chk("rst_busy",     {31'b0, b1.busy},   0);
      chk("rst_owner",    {31'b0, b1.owner},  0);
      chk("rst_ram_en",   {31'b0, b1.ram_en}, 0);
      chk("rst_ram_we",   {31'b0, b1.ram_we}, 0);
      chk("rst_ram_addr", {16'b0, b1.ram_addr}, 0);
      chk("rst_ram_wdata", b1.ram_wdata, 0);
      chk("rst_acks",     {30'b0, b1.if_ack, b1.dm_ack}, 0);
      chk("rst_if_rdata", b1.if_rdata, 0);
      chk("rst_dm_rdata", b1.dm_rdata, 0);
      nxt();
      reset = 1'b0;

      // Vector table: single transactions, latency checked here, data via scoreboard.
      for (int i = 0; i < 12; i++) begin
         expect_push(tv[i].dat, tv[i].we, tv[i].addr, tv[i].wdata);
         drive(tv[i].dat, tv[i].we, tv[i].addr, tv[i].wdata);
         wait_ack(tv[i].dat, lat);
         chk($sformatf("vec%0d_latency", i), lat, tv[i].lat);
      end

      // Cycle-exact fetch after reset.
      reset = 1'b1;
      nxt();
      smp();
      chk("rst2_if_rdata", b1.if_rdata, 0);
      chk("rst2_dm_rdata", b1.dm_rdata, 0);
      nxt();
      reset = 1'b0;
      expect_push(0, 0, 16'h0010, 0);
      drive(0, 0, 16'h0010, 0);
      smp();
      chk("f_c0_busy", {31'b0, b1.busy}, 0);
      chk("f_c0_en",   {31'b0, b1.ram_en}, 0);
      nxt(); smp();
      chk("f_c1_en",   {31'b0, b1.ram_en}, 1);
      chk("f_c1_we",   {31'b0, b1.ram_we}, 0);
      chk("f_c1_addr", {16'b0, b1.ram_addr}, 32'h0010);
      chk("f_c1_busy", {31'b0, b1.busy}, 1);
      nxt(); smp();
      chk("f_c2_en",   {31'b0, b1.ram_en}, 0);
      chk("f_c2_ack",  {31'b0, b1.if_ack}, 0);
      chk("f_c2_busy", {31'b0, b1.busy}, 1);
      nxt(); smp();
      chk("f_c3_ack",    {31'b0, b1.if_ack}, 1);
      chk("f_c3_rdata",  b1.if_rdata, 32'hDEADBEEF);
      chk("f_c3_dm_ack", {31'b0, b1.dm_ack}, 0);
      chk("f_c3_busy",   {31'b0, b1.busy}, 1);
      nxt();
      b1.if_req = 1'b0;
      smp();
      chk("f_c4_ack",  {31'b0, b1.if_ack}, 0);
      chk("f_c4_busy", {31'b0, b1.busy}, 0);
      nxt();

      // Store: one-cycle write strobe, ack in cycle 2; then fetch it back.
      expect_push(1, 1, 16'h0060, 32'h12345678);
      drive(1, 1, 16'h0060, 32'h12345678);
      smp(); nxt(); smp();
      chk("s_c1_en",    {31'b0, b1.ram_en}, 1);
      chk("s_c1_we",    {31'b0, b1.ram_we}, 1);
      chk("s_c1_addr",  {16'b0, b1.ram_addr}, 32'h0060);
      chk("s_c1_wdata", b1.ram_wdata, 32'h12345678);
      nxt(); smp();
      chk("s_c2_en",  {31'b0, b1.ram_en}, 0);
      chk("s_c2_we",  {31'b0, b1.ram_we}, 0);
      chk("s_c2_ack", {31'b0, b1.dm_ack}, 1);
      nxt();
      b1.dm_req = 1'b0;
      expect_push(0, 0, 16'h0060, 0);
      drive(0, 0, 16'h0060, 0);
      wait_ack(0, lat);
      chk("s_fetch_latency", lat, 3);

      // Tie: data granted first, fetch follows once dm_req drops.
      expect_push(1, 0, 16'h0030, 0);
      expect_push(0, 0, 16'h0000, 0);
      drive(1, 0, 16'h0030, 0);
      drive(0, 0, 16'h0000, 0);
      for (int t = 0; t < 9; t++) begin
         smp();
         case (t)
            1: begin
               chk("tie_c1_owner", {31'b0, b1.owner}, 1);
               chk("tie_c1_addr",  {16'b0, b1.ram_addr}, 32'h0030);
            end
            3: begin
               chk("tie_c3_dm_ack",   {31'b0, b1.dm_ack}, 1);
               chk("tie_c3_dm_rdata", b1.dm_rdata, 32'hA5A5A5A5);
               chk("tie_c3_if_rdata", b1.if_rdata, 32'h12345678);
            end
            5: begin
               chk("tie_c5_owner", {31'b0, b1.owner}, 0);
               chk("tie_c5_addr",  {16'b0, b1.ram_addr}, 32'h0000);
               chk("tie_c5_en",    {31'b0, b1.ram_en}, 1);
            end
            6: chk("tie_c6_if_rdata", b1.if_rdata, 32'h12345678);
            7: begin
               chk("tie_c7_if_ack",   {31'b0, b1.if_ack}, 1);
               chk("tie_c7_if_rdata", b1.if_rdata, 32'h13579BDF);
            end
            default: ;
         endcase
         nxt();
         if (t == 3) b1.dm_req = 1'b0;
         if (t == 7) b1.if_req = 1'b0;
      end

      // Continuous contention from reset: grant order checked by the scoreboard.
      reset = 1'b1;
      nxt();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) expect_push(ord[k], 0, ord[k] ? 16'h0040 : 16'h0010, 0);
      drive(1, 0, 16'h0040, 0);
      drive(0, 0, 16'h0010, 0);
      n = 0;
      for (int t = 0; t < 40 && n < 4; t++) begin
         smp();
         if (b1.if_ack || b1.dm_ack) n++;
         nxt();
      end
      b1.dm_req = 1'b0;
      b1.if_req = 1'b0;
      chk("contention_acks", n, 4);
      nxt();

      // Reset during WAIT of a load: abandoned, then replayed from IDLE.
      drive(1, 0, 16'h0030, 0);
      smp(); nxt(); smp();
      chk("ra_c1_en", {31'b0, b1.ram_en}, 1);
      nxt();
      reset = 1'b1;
      smp();
      chk("ra_c2_busy", {31'b0, b1.busy}, 1);
      nxt(); smp();
      chk("ra_c3_busy",   {31'b0, b1.busy}, 0);
      chk("ra_c3_en",     {31'b0, b1.ram_en}, 0);
      chk("ra_c3_ack",    {31'b0, b1.dm_ack}, 0);
      chk("ra_c3_rdata",  b1.dm_rdata, 0);
      chk("ra_c3_owner",  {31'b0, b1.owner}, 0);
      nxt();
      reset = 1'b0;
      expect_push(1, 0, 16'h0030, 0);
      wait_ack(1, lat);
      chk("ra_replay_latency", lat, 3);

      // RD_LAT=3 fetch on the second instance.
      b3.if_req  = 1'b1;
      b3.if_addr = 16'h0050;
      for (int t = 0; t < 7; t++) begin
         smp();
         chk($sformatf("l3_c%0d_en", t),   {31'b0, b3.ram_en}, {31'b0, t == 1});
         chk($sformatf("l3_c%0d_ack", t),  {31'b0, b3.if_ack}, {31'b0, t == 5});
         chk($sformatf("l3_c%0d_busy", t), {31'b0, b3.busy},   {31'b0, t >= 1 && t <= 5});
         if (t == 5) chk("l3_rdata", b3.if_rdata, pat(16'h0050));
         nxt();
         if (t == 5) b3.if_req = 1'b0;
      end

      chk("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Arbitrates the single-port instruction/data RAM between two requesters: the instruction-fetch port (read-only) and the data-memory port used by LDR (opcode 1101) and STR (opcode 1110). Both use a req/ack handshake. The block owns ram_en/ram_we/ram_addr/ram_wdata and sequences each access through a small FSM. It replaces ad-hoc address-mux and RW control with one registered owner of the RAM bus.

Parameters:
ADDR_W, 16, RAM address width
DATA_W, 32, RAM data width
RD_LAT, 1, cycles from ram_en to valid ram_rdata; legal 1..4

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  ADDR_W  fetch address, stable while if_req high
if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid
if_rdata  out  DATA_W  fetched word, held until next fetch completes
dm_req  in  1  data request, held until dm_ack
dm_we  in  1  1 = STR write, 0 = LDR read; stable while dm_req high
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_ack  out  1  one-cycle pulse: data access complete
dm_rdata  out  DATA_W  load data, held until next data read completes
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable, valid only with ram_en
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data
busy  out  1  high when state != IDLE
owner  out  1  0 = fetch, 1 = data; port currently granted

Behaviour:
- Clock port is clock; reset port is reset. Reset is synchronous and active-high.
- Reset: state=IDLE. All outputs 0, including rdata registers and owner. An in-flight access is abandoned with no ack.
- All outputs are registered. There is no combinational path from req to ram_* or ack.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: sample the requests.
  - dm_req=1: owner<=1. Latch dm_addr, dm_we and dm_wdata. Go to ACCESS.
  - else if_req=1: owner<=0. Latch if_addr, we=0. Go to ACCESS.
  - else stay in IDLE.
  - Default tie rule: data wins.
- ACCESS (exactly 1 cycle): ram_en=1, ram_we=latched we, ram_addr and ram_wdata driven from the latches.
  - Write: go to RESP.
  - Read: load lat_cnt=RD_LAT and go to WAIT.
- WAIT: lat_cnt decrements each cycle. In the cycle where lat_cnt==1:
  - capture ram_rdata into the owner's rdata register (only the owner's register updates);
  - go to RESP.
- RESP (1 cycle): the owner's ack=1, then go to IDLE.
- ram_en and ram_we are 0 in every state except ACCESS. ram_addr and ram_wdata hold their last values.
- Timing with requests first seen in IDLE at cycle 0:
  - read: ram_en in cycle 1, ack in cycle 2+RD_LAT;
  - write: ram_we in cycle 1, ack in cycle 2.
  - Peak throughput for back-to-back reads: one per 3+RD_LAT cycles.
- Handshake rules:
  - The requester updates req on the edge where it samples ack. A req still high in the cycle after ack counts as a new request.
  - Dropping req before ack is illegal; the access completes regardless.
- A request arriving while busy waits; the arbiter re-arbitrates in IDLE.
- dm_we is ignored unless owner=1. The fetch port never writes.
- Starvation: under default priority, fetch waits only while dm_req is continuously asserted. The pipeline issues at most one data access per instruction, so the wait is bounded.
- RD_LAT outside 1..4 is unsupported. lat_cnt is 3 bits.

Optional Feature:
ARB_RR_EN:
- Defined: a last_owner register is added, reset to 0 (fetch), updated on each grant. When both requests are present in IDLE, the port opposite last_owner is granted. The first tie after reset therefore goes to data; continuous contention alternates grants.
- Undefined: fixed priority, data always wins ties, and no last_owner register is built.

Test Plan:
1. Fetch read, RD_LAT=1, RAM[0x0010]=0xDEADBEEF. Reset, then if_req with if_addr=0x0010 at cycle 0 → ram_en=1, ram_we=0, ram_addr=0x0010 in cycle 1; if_ack pulse in cycle 3 with if_rdata=0xDEADBEEF; dm_ack stays 0; busy high in cycles 1–3.
2. Store then fetch. dm_req, dm_we=1, dm_addr=0x0020, dm_wdata=0x12345678 → ram_en=ram_we=1 for exactly one cycle (cycle 1), dm_ack in cycle 2. A following fetch of 0x0020 returns 0x12345678.
3. Tie without ARB_RR_EN. if_req (0x0000) and dm_req (LDR 0x0030, RAM=0xA5A5A5A5) both at cycle 0 → owner=1, dm_ack in cycle 3 with dm_rdata=0xA5A5A5A5. Fetch then granted at cycle 4, if_ack in cycle 7. if_rdata is unchanged until then.
4. Tie with ARB_RR_EN. Both requests held continuously for 4 transactions → grant order data, fetch, data, fetch.
5. RD_LAT=3 fetch → ram_en in cycle 1, if_ack in cycle 5. ram_rdata is captured from cycle 4.
6. Reset mid-access. Reset asserted in WAIT of a data read → next cycle: busy=0, ram_en=0, dm_ack never pulses, dm_rdata=0. With dm_req still high after reset release, the read re-executes from IDLE with normal timing.
